// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU command constants, sequencer state type and command legality helper
package alu_pkg;

    localparam logic [3:0] CMD_AND  = 4'd0;
    localparam logic [3:0] CMD_OR   = 4'd1;
    localparam logic [3:0] CMD_XOR  = 4'd2;
    localparam logic [3:0] CMD_NOT  = 4'd3;
    localparam logic [3:0] CMD_UADD = 4'd4;
    localparam logic [3:0] CMD_SADD = 4'd5;

    localparam int unsigned NUM_ALU_CMDS = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    // Commands are numbered densely from zero, so legality is a single bound check.
    function automatic logic cmd_is_legal(input logic [3:0] cmd, input int unsigned num_cmds);
        return (32'(cmd) < num_cmds);
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU placed beside alu_sequencer at the parent level
//
// Purpose: bitwise and add operations on SIZE-bit operands, 2*SIZE-bit result.
//   AND/OR/XOR/NOT produce a zero-extended SIZE-bit value.
//   UADD: exact unsigned sum, overflow = carry out of SIZE bits.
//   SADD: exact signed sum sign-extended, overflow = SIZE-bit signed overflow.
//   Result and overflow are 0 while enable is low or for unknown commands.
// Ports:
//   enable    in   1       operation strobe
//   command   in   4       operation select
//   a, b      in   SIZE    operands
//   result    out  2*SIZE  operation result
//   overflow  out  1       overflow flag for the add operations
module alu
    import alu_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic              enable,
    input  logic [3:0]        command,
    input  logic [SIZE-1:0]   a,
    input  logic [SIZE-1:0]   b,
    output logic [2*SIZE-1:0] result,
    output logic              overflow
);

    logic [SIZE:0] usum;
    logic [SIZE:0] ssum;

    always_comb begin
        usum     = {1'b0, a} + {1'b0, b};
        ssum     = {a[SIZE-1], a} + {b[SIZE-1], b};
        result   = '0;
        overflow = 1'b0;
        if (enable) begin
            case (command)
                CMD_AND:  result = {{SIZE{1'b0}}, a & b};
                CMD_OR:   result = {{SIZE{1'b0}}, a | b};
                CMD_XOR:  result = {{SIZE{1'b0}}, a ^ b};
                CMD_NOT:  result = {{SIZE{1'b0}}, ~a};
                CMD_UADD: begin
                    result   = {{(SIZE-1){1'b0}}, usum};
                    overflow = usum[SIZE];
                end
                CMD_SADD: begin
                    // The SIZE+1-bit sum is exact; overflow flags that it does not fit in SIZE bits.
                    result   = {{(SIZE-1){ssum[SIZE]}}, ssum};
                    overflow = ssum[SIZE] ^ ssum[SIZE-1];
                end
                default: begin
                    result   = '0;
                    overflow = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - request/response sequencer that issues one op at a time to a combinational alu
//
// Purpose: accepts tagged op requests, drives one ALU issue cycle, captures the
//   result and returns a tagged response. Illegal commands (>= NUM_CMDS) are
//   answered with an error response and never reach the alu.
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   req_valid/req_ready               request handshake
//   req_cmd/req_a/req_b/req_tag       request payload
//   alu_enable/alu_command/alu_a/b    drive to the alu
//   alu_result/alu_overflow           sampled from the alu at the end of the issue cycle
//   resp_valid/resp_ready             response handshake
//   resp_result/overflow/error/tag    response payload, stable while resp_valid
//   op_count                          completed response handshakes, wraps
//   err_count                         error response handshakes, saturates
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int SIZE     = 8,
    parameter int TAG_W    = 4,
    parameter int NUM_CMDS = NUM_ALU_CMDS,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_cmd,
    input  logic [SIZE-1:0]   req_a,
    input  logic [SIZE-1:0]   req_b,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              alu_enable,
    output logic [3:0]        alu_command,
    output logic [SIZE-1:0]   alu_a,
    output logic [SIZE-1:0]   alu_b,
    input  logic              alu_overflow,
    input  logic [2*SIZE-1:0] alu_result,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [2*SIZE-1:0] resp_result,
    output logic              resp_overflow,
    output logic              resp_error,
    output logic [TAG_W-1:0]  resp_tag,
    output logic [CNT_W-1:0]  op_count,
    output logic [CNT_W-1:0]  err_count
);

    localparam int unsigned NUM_CMDS_U = NUM_CMDS;

    state_e              state_q,   state_d;
    logic [3:0]          cmd_q,     cmd_d;
    logic [SIZE-1:0]     a_q,       a_d;
    logic [SIZE-1:0]     b_q,       b_d;
    logic [TAG_W-1:0]    tag_q,     tag_d;
    logic [2*SIZE-1:0]   res_q,     res_d;
    logic                ovf_q,     ovf_d;
    logic                err_q,     err_d;
    logic [CNT_W-1:0]    op_cnt_q,  op_cnt_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            tag_q     <= '0;
            res_q     <= '0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            op_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            a_q       <= a_d;
            b_q       <= b_d;
            tag_q     <= tag_d;
            res_q     <= res_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
            op_cnt_q  <= op_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        a_d        = a_q;
        b_d        = b_q;
        tag_d      = tag_q;
        res_d      = res_q;
        ovf_d      = ovf_q;
        err_d      = err_q;
        op_cnt_d   = op_cnt_q;
        err_cnt_d  = err_cnt_q;
        req_ready  = 1'b0;
        alu_enable = 1'b0;
        resp_valid = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    cmd_d = req_cmd;
                    a_d   = req_a;
                    b_d   = req_b;
                    tag_d = req_tag;
                    if (cmd_is_legal(req_cmd, NUM_CMDS_U)) begin
                        state_d = ISSUE;
                    end else begin
                        // Rejected locally: the response is fully formed now, so skip the issue cycle.
                        res_d   = '0;
                        ovf_d   = 1'b0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            ISSUE: begin
                alu_enable = 1'b1;
                res_d      = alu_result;
                ovf_d      = alu_overflow;
                err_d      = 1'b0;
                state_d    = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d  = IDLE;
                    op_cnt_d = op_cnt_q + CNT_W'(1);
                    if (err_q && (err_cnt_q != {CNT_W{1'b1}})) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign alu_command   = cmd_q;
    assign alu_a         = a_q;
    assign alu_b         = b_q;
    assign resp_result   = res_q;
    assign resp_overflow = ovf_q;
    assign resp_error    = err_q;
    assign resp_tag      = tag_q;
    assign op_count      = op_cnt_q;
    assign err_count     = err_cnt_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer wired to a real alu
module tb_alu_sequencer;

    localparam int SIZE  = 8;
    localparam int TAG_W = 4;
    localparam int CNT_W = 4;
    localparam int CNT_MOD = 1 << CNT_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [3:0]        req_cmd = '0;
    logic [SIZE-1:0]   req_a = '0;
    logic [SIZE-1:0]   req_b = '0;
    logic [TAG_W-1:0]  req_tag = '0;
    logic              alu_enable;
    logic [3:0]        alu_command;
    logic [SIZE-1:0]   alu_a;
    logic [SIZE-1:0]   alu_b;
    logic              alu_overflow;
    logic [2*SIZE-1:0] alu_result;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [2*SIZE-1:0] resp_result;
    logic              resp_overflow;
    logic              resp_error;
    logic [TAG_W-1:0]  resp_tag;
    logic [CNT_W-1:0]  op_count;
    logic [CNT_W-1:0]  err_count;

    int checks = 0;
    int errors = 0;
    logic chk_on = 1'b0;

    always #5 clk = ~clk;

    alu_sequencer #(.SIZE(SIZE), .TAG_W(TAG_W), .NUM_CMDS(6), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .alu_enable(alu_enable), .alu_command(alu_command), .alu_a(alu_a), .alu_b(alu_b),
        .alu_overflow(alu_overflow), .alu_result(alu_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .resp_overflow(resp_overflow), .resp_error(resp_error), .resp_tag(resp_tag),
        .op_count(op_count), .err_count(err_count)
    );

    alu #(.SIZE(SIZE)) u_alu (
        .enable(alu_enable), .command(alu_command), .a(alu_a), .b(alu_b),
        .result(alu_result), .overflow(alu_overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU behaviour from plain integer arithmetic: {overflow, result}.
    function automatic logic [16:0] alu_model(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        int s;
        case (c)
            4'd0: return {9'h000, a & b};
            4'd1: return {9'h000, a | b};
            4'd2: return {9'h000, a ^ b};
            4'd3: return {9'h000, ~a};
            4'd4: begin
                s = int'(a) + int'(b);
                return {(s > 255), 16'(s)};
            end
            4'd5: begin
                s = int'($signed(a)) + int'($signed(b));
                return {((s > 127) || (s < -128)), 16'(s)};
            end
            default: return 17'h0;
        endcase
    endfunction

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        logic        err;
        logic [3:0]  tag;
    } resp_t;

    resp_t      exp_q[$];
    logic       exp_en = 1'b0;
    logic       exp_rv = 1'b0;
    int         exp_ops = 0;
    int         exp_errs = 0;
    logic [3:0] m_cmd = '0;
    logic [7:0] m_a = '0;
    logic [7:0] m_b = '0;

    // Compare on the falling edge, then advance the model by the upcoming rising edge.
    always @(negedge clk) begin
        resp_t      r;
        logic [16:0] mv;
        logic       nxt_en;
        logic       nxt_rv;
        if (chk_on) begin
            chk("req_ready", 32'(req_ready), 32'(!(exp_en || exp_rv)));
            chk("alu_enable", 32'(alu_enable), 32'(exp_en));
            chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
            chk("alu_command", 32'(alu_command), 32'(m_cmd));
            chk("alu_a", 32'(alu_a), 32'(m_a));
            chk("alu_b", 32'(alu_b), 32'(m_b));
            chk("op_count", 32'(op_count), 32'(exp_ops));
            chk("err_count", 32'(err_count), 32'(exp_errs));
            if (exp_rv) begin
                if (exp_q.size() == 0) begin
                    chk("resp_queue_nonempty", 32'(0), 32'(1));
                end else begin
                    chk("resp_result", 32'(resp_result), 32'(exp_q[0].res));
                    chk("resp_overflow", 32'(resp_overflow), 32'(exp_q[0].ovf));
                    chk("resp_error", 32'(resp_error), 32'(exp_q[0].err));
                    chk("resp_tag", 32'(resp_tag), 32'(exp_q[0].tag));
                end
            end
        end
        if (!rst_n) begin
            exp_q.delete();
            exp_en = 1'b0;
            exp_rv = 1'b0;
            exp_ops = 0;
            exp_errs = 0;
            m_cmd = '0;
            m_a = '0;
            m_b = '0;
        end else begin
            nxt_en = 1'b0;
            nxt_rv = exp_rv;
            if (exp_rv && resp_ready) begin
                if (exp_q.size() != 0) begin
                    if (exp_q[0].err && exp_errs < CNT_MOD - 1) exp_errs++;
                    void'(exp_q.pop_front());
                end
                exp_ops = (exp_ops + 1) % CNT_MOD;
                nxt_rv = 1'b0;
            end
            if (exp_en) nxt_rv = 1'b1;
            if (req_valid && !exp_en && !exp_rv) begin
                m_cmd = req_cmd;
                m_a = req_a;
                m_b = req_b;
                if (req_cmd < 4'd6) begin
                    mv = alu_model(req_cmd, req_a, req_b);
                    r.res = mv[15:0];
                    r.ovf = mv[16];
                    r.err = 1'b0;
                    nxt_en = 1'b1;
                end else begin
                    r.res = '0;
                    r.ovf = 1'b0;
                    r.err = 1'b1;
                    nxt_rv = 1'b1;
                end
                r.tag = req_tag;
                exp_q.push_back(r);
            end
            exp_en = nxt_en;
            exp_rv = nxt_rv;
        end
    end

    // One complete transaction with hand-computed expectations. Inputs change 1 time unit after posedge.
    task automatic run_op(input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] tag, input int hold,
                          input logic [15:0] e_res, input logic e_ovf, input logic e_err);
        int wait_c;
        int lat;
        int en_cycles;
        wait_c = 0;
        while (!req_ready && wait_c < 20) begin
            @(posedge clk); #1;
            wait_c++;
        end
        chk("req_ready_wait", 32'(req_ready), 32'(1));
        req_valid = 1'b1;
        req_cmd = cmd;
        req_a = a;
        req_b = b;
        req_tag = tag;
        resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        en_cycles = 0;
        while (!resp_valid && lat < 10) begin
            if (alu_enable) en_cycles++;
            @(posedge clk); #1;
            lat++;
        end
        chk("resp_latency", 32'(lat), e_err ? 32'(1) : 32'(2));
        chk("enable_cycles", 32'(en_cycles), e_err ? 32'(0) : 32'(1));
        chk("lit_result", 32'(resp_result), 32'(e_res));
        chk("lit_overflow", 32'(resp_overflow), 32'(e_ovf));
        chk("lit_error", 32'(resp_error), 32'(e_err));
        chk("lit_tag", 32'(resp_tag), 32'(tag));
        for (int i = 1; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(resp_valid), 32'(1));
            chk("hold_req_ready", 32'(req_ready), 32'(0));
            chk("hold_result", 32'(resp_result), 32'(e_res));
            chk("hold_tag", 32'(resp_tag), 32'(tag));
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("post_hs_valid", 32'(resp_valid), 32'(0));
        chk("post_hs_req_ready", 32'(req_ready), 32'(1));
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_on = 1'b1;
        chk("rst_req_ready", 32'(req_ready), 32'(1));
        chk("rst_resp_valid", 32'(resp_valid), 32'(0));
        chk("rst_alu_enable", 32'(alu_enable), 32'(0));
        chk("rst_op_count", 32'(op_count), 32'(0));
        chk("rst_resp_result", 32'(resp_result), 32'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset while the op is in its issue cycle: dropped without a response.
        req_valid = 1'b1;
        req_cmd = 4'd0;
        req_a = 8'hFF;
        req_b = 8'h0F;
        req_tag = 4'd9;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("mid_issue_enable", 32'(alu_enable), 32'(1));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'(0));
        chk("mid_rst_enable", 32'(alu_enable), 32'(0));
        chk("mid_rst_req_ready", 32'(req_ready), 32'(1));
        chk("mid_rst_op_count", 32'(op_count), 32'(0));
        run_op(4'd1, 8'h12, 8'h21, 4'd1, 0, 16'h0033, 1'b0, 1'b0);

        // Fifteen more ANDs bring op_count to sixteen handshakes, which wraps a 4-bit counter.
        for (int i = 0; i < 15; i++) begin
            run_op(4'd0, 8'(i * 17), 8'hFF, 4'(i), 0, 16'(i * 17), 1'b0, 1'b0);
        end
        chk("wrap_op_count", 32'(op_count), 32'(0));
        chk("wrap_err_count", 32'(err_count), 32'(0));

        run_op(4'd0, 8'hF0, 8'h3C, 4'd3, 1, 16'h0030, 1'b0, 1'b0);
        run_op(4'd3, 8'h5A, 8'h00, 4'd4, 1, 16'h00A5, 1'b0, 1'b0);
        run_op(4'hF, 8'h11, 8'h22, 4'd7, 1, 16'h0000, 1'b0, 1'b1);
        chk("err_count_one", 32'(err_count), 32'(1));
        run_op(4'd2, 8'hAA, 8'h0F, 4'd5, 1, 16'h00A5, 1'b0, 1'b0);
        run_op(4'd4, 8'hFF, 8'h02, 4'd6, 1, 16'h0101, 1'b1, 1'b0);
        run_op(4'd4, 8'h10, 8'h20, 4'd8, 0, 16'h0030, 1'b0, 1'b0);
        run_op(4'd5, 8'h7F, 8'h01, 4'd10, 1, 16'h0080, 1'b1, 1'b0);
        run_op(4'd5, 8'h80, 8'hFF, 4'd11, 1, 16'hFF7F, 1'b1, 1'b0);
        run_op(4'd5, 8'hFE, 8'h01, 4'd12, 1, 16'hFFFF, 1'b0, 1'b0);
        run_op(4'd6, 8'h01, 8'h01, 4'd13, 1, 16'h0000, 1'b0, 1'b1);
        // Response held back for five cycles, handshake on the sixth.
        run_op(4'd1, 8'h0C, 8'h30, 4'd2, 6, 16'h003C, 1'b0, 1'b0);

        // Further errors push err_count into saturation.
        for (int i = 0; i < 15; i++) begin
            run_op(4'(8 + (i % 8)), 8'(i), 8'(i), 4'(i), 0, 16'h0000, 1'b0, 1'b1);
        end
        chk("err_count_saturated", 32'(err_count), 32'(15));

        @(posedge clk); #1;
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
